// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsa_pkg
// Brief    : State codes, opcodes and load targets shared by rsa_exp blocks.
// Revision : 1.0 - initial release
// ============================================================================
package rsa_pkg;

  typedef logic [3:0] state_t;

  localparam state_t C_ST_IDLE    = 4'd0;
  localparam state_t C_ST_RX      = 4'd1;
  localparam state_t C_ST_RX_WAIT = 4'd2;
  localparam state_t C_ST_LOAD    = 4'd3;
  localparam state_t C_ST_PRE     = 4'd4;
  localparam state_t C_ST_SQ      = 4'd5;
  localparam state_t C_ST_MUL     = 4'd6;
  localparam state_t C_ST_POST    = 4'd7;
  localparam state_t C_ST_TX      = 4'd8;
  localparam state_t C_ST_TX_WAIT = 4'd9;
  localparam state_t C_ST_DONE    = 4'd10;
  localparam state_t C_ST_ERR     = 4'd11;

  localparam logic [3:0] C_OP_IDLE = 4'h0;
  localparam logic [3:0] C_OP_LOAD = 4'h1;
  localparam logic [3:0] C_OP_EXP  = 4'h2;
  localparam logic [3:0] C_OP_MUL  = 4'h3;

  localparam logic [2:0] C_SEL_N   = 3'd1;
  localparam logic [2:0] C_SEL_RN  = 3'd2;
  localparam logic [2:0] C_SEL_R2N = 3'd3;
  localparam logic [2:0] C_SEL_EXP = 4'd4;
  localparam logic [2:0] C_SEL_X   = 3'd5;

  function automatic logic is_busy(input state_t s);
    return !((s == C_ST_IDLE) || (s == C_ST_DONE) || (s == C_ST_ERR));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_exp_ctrl
// Brief    : Sequencing FSM and exponent bit counter for rsa_exp.
//            RSA_EXP_CONST_TIME_EN: run a MUL pass for every exponent bit.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int EXP_WIDTH = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   i_opcode,
  input  logic [$clog2(EXP_WIDTH):0]   i_exp_len,
  input  logic                         i_exp_bit,
  input  logic                         i_dma_idle,
  input  logic                         i_dma_done,
  input  logic                         i_dma_error,
  input  logic                         i_mm_done,
  output state_t                       o_state,
  output logic [$clog2(EXP_WIDTH)-1:0] o_bit_idx,
  output logic                         o_op_mul,
  output logic                         o_dma_rx_start,
  output logic                         o_dma_tx_start,
  output logic                         o_mm_start
);

  localparam int LEN_W = $clog2(EXP_WIDTH) + 1;
  localparam int IDX_W = $clog2(EXP_WIDTH);
  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(EXP_WIDTH);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_first;
  logic             r_op_mul;

  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_len_m1;
  logic             w_last;
  logic             w_sq_to_mul;

  assign w_len_eff = (i_exp_len > C_LEN_MAX) ? C_LEN_MAX : i_exp_len;
  assign w_len_m1  = w_len_eff - LEN_W'(1);
  assign w_last    = (r_idx == '0);

`ifdef RSA_EXP_CONST_TIME_EN
  logic w_unused_bit;
  assign w_unused_bit = i_exp_bit;
  assign w_sq_to_mul  = 1'b1;
`else
  assign w_sq_to_mul  = i_exp_bit;
`endif

  // r_first marks the first cycle of every multiplier pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= C_ST_IDLE;
      r_idx    <= '0;
      r_first  <= 1'b0;
      r_op_mul <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (i_opcode == C_OP_LOAD) begin
            r_state <= C_ST_RX;
          end else if ((i_opcode == C_OP_EXP) || (i_opcode == C_OP_MUL)) begin
            r_state  <= C_ST_PRE;
            r_first  <= 1'b1;
            r_op_mul <= (i_opcode == C_OP_MUL);
          end
        end
        C_ST_RX:      if (i_dma_idle) r_state <= C_ST_RX_WAIT;
        C_ST_RX_WAIT: begin
          if (i_dma_error)     r_state <= C_ST_ERR;
          else if (i_dma_done) r_state <= C_ST_LOAD;
        end
        C_ST_LOAD:    r_state <= C_ST_DONE;
        C_ST_PRE: begin
          if (i_mm_done) begin
            if (r_op_mul) begin
              r_state <= C_ST_TX;
            end else if (w_len_eff == '0) begin
              r_state <= C_ST_POST;
              r_first <= 1'b1;
            end else begin
              r_state <= C_ST_SQ;
              r_idx   <= w_len_m1[IDX_W-1:0];
              r_first <= 1'b1;
            end
          end
        end
        C_ST_SQ: begin
          if (i_mm_done) begin
            r_first <= 1'b1;
            if (w_sq_to_mul)  r_state <= C_ST_MUL;
            else if (w_last)  r_state <= C_ST_POST;
            else              r_idx   <= r_idx - IDX_W'(1);
          end
        end
        C_ST_MUL: begin
          if (i_mm_done) begin
            r_first <= 1'b1;
            if (w_last) begin
              r_state <= C_ST_POST;
            end else begin
              r_state <= C_ST_SQ;
              r_idx   <= r_idx - IDX_W'(1);
            end
          end
        end
        C_ST_POST:    if (i_mm_done) r_state <= C_ST_TX;
        C_ST_TX:      if (i_dma_idle) r_state <= C_ST_TX_WAIT;
        C_ST_TX_WAIT: begin
          if (i_dma_error)     r_state <= C_ST_ERR;
          else if (i_dma_done) r_state <= C_ST_DONE;
        end
        C_ST_DONE, C_ST_ERR: if (i_opcode == C_OP_IDLE) r_state <= C_ST_IDLE;
        default:      r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_bit_idx      = r_idx;
  assign o_op_mul       = r_op_mul;
  assign o_mm_start     = r_first;
  assign o_dma_rx_start = (r_state == C_ST_RX) && i_dma_idle;
  assign o_dma_tx_start = (r_state == C_ST_TX) && i_dma_idle;

endmodule
`default_nettype wire

// File: rtl/rsa_exp.sv
`default_nettype none
// ============================================================================
// Module   : rsa_exp
// Brief    : Left-to-right Montgomery modular exponentiation, DMA fed.
//            RSA_EXP_CONST_TIME_EN: exponent-independent multiply schedule.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_exp
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int DMA_WIDTH = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                command,
  input  logic [2:0]                 load_sel,
  input  logic [$clog2(EXP_WIDTH):0] exp_len,
  output logic [31:0]                status,
  input  logic [DMA_WIDTH-1:0]       dma_rx_data,
  output logic [DMA_WIDTH-1:0]       dma_tx_data,
  output logic                       dma_rx_start,
  output logic                       dma_tx_start,
  input  logic                       dma_done,
  input  logic                       dma_idle,
  input  logic                       dma_error,
  output logic                       mm_start,
  output logic [WIDTH-1:0]           mm_a,
  output logic [WIDTH-1:0]           mm_b,
  output logic [WIDTH-1:0]           mm_m,
  input  logic [WIDTH-1:0]           mm_result,
  input  logic                       mm_done
);

  state_t                       w_state;
  logic [$clog2(EXP_WIDTH)-1:0] w_bit_idx;
  logic                         w_op_mul;
  logic                         w_exp_bit;
  logic                         w_busy;
  logic                         w_done;
  logic [EXP_WIDTH-1:0]         w_rx_exp;
  logic                         w_unused_cmd;

  logic [WIDTH-1:0]     r_n;
  logic [WIDTH-1:0]     r_rn;
  logic [WIDTH-1:0]     r_r2n;
  logic [WIDTH-1:0]     r_x;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_xt;
  logic [WIDTH-1:0]     r_result;

  assign w_unused_cmd = ^command[31:4];

  if (EXP_WIDTH <= DMA_WIDTH) begin : g_exp_narrow
    assign w_rx_exp = dma_rx_data[EXP_WIDTH-1:0];
  end else begin : g_exp_wide
    assign w_rx_exp = {{(EXP_WIDTH-DMA_WIDTH){1'b0}}, dma_rx_data};
  end

  rsa_exp_ctrl #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .i_opcode       (command[3:0]),
    .i_exp_len      (exp_len),
    .i_exp_bit      (w_exp_bit),
    .i_dma_idle     (dma_idle),
    .i_dma_done     (dma_done),
    .i_dma_error    (dma_error),
    .i_mm_done      (mm_done),
    .o_state        (w_state),
    .o_bit_idx      (w_bit_idx),
    .o_op_mul       (w_op_mul),
    .o_dma_rx_start (dma_rx_start),
    .o_dma_tx_start (dma_tx_start),
    .o_mm_start     (mm_start)
  );

  assign w_exp_bit = r_exp[w_bit_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n      <= '0;
      r_rn     <= '0;
      r_r2n    <= '0;
      r_x      <= '0;
      r_exp    <= '0;
      r_a      <= '0;
      r_xt     <= '0;
      r_result <= '0;
    end else begin
      if (w_state == C_ST_LOAD) begin
        case (load_sel)
          C_SEL_N:   r_n   <= dma_rx_data;
          C_SEL_RN:  r_rn  <= dma_rx_data;
          C_SEL_R2N: r_r2n <= dma_rx_data;
          C_SEL_EXP: r_exp <= w_rx_exp;
          C_SEL_X:   r_x   <= dma_rx_data;
          default:   ;
        endcase
      end
      if (mm_done) begin
        case (w_state)
          C_ST_PRE: begin
            r_xt <= mm_result;
            r_a  <= r_rn;
            if (w_op_mul) r_result <= mm_result;
          end
          C_ST_SQ:   r_a <= mm_result;
          // Gating on the bit is a no-op unless every bit gets a MUL pass
          C_ST_MUL:  if (w_exp_bit) r_a <= mm_result;
          C_ST_POST: r_result <= mm_result;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (w_state)
      C_ST_PRE:  begin mm_a = r_x; mm_b = r_r2n;      end
      C_ST_SQ:   begin mm_a = r_a; mm_b = r_a;        end
      C_ST_MUL:  begin mm_a = r_a; mm_b = r_xt;       end
      C_ST_POST: begin mm_a = r_a; mm_b = WIDTH'(1);  end
      default:   ;
    endcase
  end

  assign mm_m        = r_n;
  assign dma_tx_data = r_result;
  assign w_busy      = is_busy(w_state);
  assign w_done      = (w_state == C_ST_DONE);
  assign status      = {26'b0, w_state, w_busy, w_done};

endmodule
`default_nettype wire
